// File: rtl/buffer_2_if.sv
// Handshake/data bundle for the radix-2 butterfly stage: two enables and
// three packed complex inputs in, two packed complex results plus a fresh-result flag out.
interface buffer_2_if #(
   parameter int HALF_W = 16
);
   logic                  enable_1;
   logic                  enable_2;
   logic [2*HALF_W-1:0]   data1;
   logic [2*HALF_W-1:0]   data2;
   logic [2*HALF_W-1:0]   w;
   logic [2*HALF_W-1:0]   out1;
   logic [2*HALF_W-1:0]   out2;
   logic                  rdy;

   // Driver side (feeds samples and enables, observes results)
   modport master (
      output enable_1, enable_2, data1, data2, w,
      input  out1, out2, rdy
   );

   // Butterfly side
   modport slave (
      input  enable_1, enable_2, data1, data2, w,
      output out1, out2, rdy
   );
endinterface

// File: rtl/buffer_2.sv
// Two-stage radix-2 DIT butterfly: stage 1 registers A and the complex
// product B*w, stage 2 forms A+B*w and A-B*w. Complex words pack the real part
// in the low half and the imaginary part in the high half, signed fixed point
// with FRAC fractional bits. All arithmetic wraps; nothing saturates.
module buffer_2 #(
   parameter int HALF_W = 16,
   parameter int FRAC   = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   buffer_2_if.slave bus
);
   localparam int CW = 2 * HALF_W;   // packed complex word
   localparam int PW = 2 * HALF_W;   // one partial product
   localparam int SW = PW + 1;       // sum/difference of two partial products

   logic [CW-1:0] a_reg;
   logic [CW-1:0] p_reg;
   logic          valid1_reg;
   logic [CW-1:0] out1_reg;
   logic [CW-1:0] out2_reg;
   logic          rdy_reg;

   logic signed [HALF_W-1:0] b_re, b_im, w_re, w_im;
   logic signed [PW-1:0]     pp_rr, pp_ii, pp_ri, pp_ir;
   logic signed [SW-1:0]     sum_re, sum_im;
   logic [CW-1:0]            p_next;
   logic [CW-1:0]            out1_next;
   logic [CW-1:0]            out2_next;
   logic                     load2;

   assign b_re = bus.data2[HALF_W-1:0];
   assign b_im = bus.data2[CW-1:HALF_W];
   assign w_re = bus.w[HALF_W-1:0];
   assign w_im = bus.w[CW-1:HALF_W];

   // Full-precision partial products; the sign-extending casts keep the
   // multiplies signed at product width.
   assign pp_rr = PW'(b_re) * PW'(w_re);
   assign pp_ii = PW'(b_im) * PW'(w_im);
   assign pp_ri = PW'(b_re) * PW'(w_im);
   assign pp_ir = PW'(b_im) * PW'(w_re);

   // One extra bit so the combination of two full products cannot overflow
   // before rescaling.
   assign sum_re = SW'(pp_rr) - SW'(pp_ii);
   assign sum_im = SW'(pp_ri) + SW'(pp_ir);

   // Drop the fractional bits (floor) and keep the low component width.
   assign p_next = {HALF_W'(sum_im >>> FRAC), HALF_W'(sum_re >>> FRAC)};

   // Componentwise add/subtract for stage 2, one lane per real/imag half.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane
         assign out1_next[gi*HALF_W +: HALF_W] =
            a_reg[gi*HALF_W +: HALF_W] + p_reg[gi*HALF_W +: HALF_W];
         assign out2_next[gi*HALF_W +: HALF_W] =
            a_reg[gi*HALF_W +: HALF_W] - p_reg[gi*HALF_W +: HALF_W];
      end
   endgenerate

   // Stage 2 fires only when it has a sample to consume.
   assign load2 = bus.enable_2 & valid1_reg;

   // Stage 1: capture A and the scaled product B*w.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= '0;
         p_reg <= '0;
      end else if (bus.enable_1) begin
         a_reg <= bus.data1;
         p_reg <= p_next;
      end
   end

   // Stage-1 occupancy: set by a load, cleared when stage 2 consumes it
   // without a replacement arriving on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid1_reg <= 1'b0;
      end else if (bus.enable_1) begin
         valid1_reg <= 1'b1;
      end else if (load2) begin
         valid1_reg <= 1'b0;
      end
   end

   // Stage 2: butterfly sum/difference; rdy marks an update on this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out1_reg <= '0;
         out2_reg <= '0;
         rdy_reg  <= 1'b0;
      end else begin
         rdy_reg <= load2;
         if (load2) begin
            out1_reg <= out1_next;
            out2_reg <= out2_next;
         end
      end
   end

   assign bus.out1 = out1_reg;
   assign bus.out2 = out2_reg;
   assign bus.rdy  = rdy_reg;
endmodule

// File: tb/tb_buffer_2.sv
// Bench for buffer_2: directed table of known butterflies, hand-written
// enable/reset sequences, and randomized traffic against a sample-level model.
module tb_buffer_2;
   logic clk = 1'b0;
   logic rst_n;

   buffer_2_if bus ();

   buffer_2 u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int ncyc = 0;

   // Reference model state: the sample waiting between stages and the outputs.
   logic        m_valid;
   logic [31:0] m_a, m_b, m_w;
   logic [31:0] m_out1, m_out2;
   logic        m_rdy;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] tw;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   vec_t tbl [3];

   // Butterfly from plain integer arithmetic; returns {out2, out1}.
   function automatic logic [63:0] bfly(input logic [31:0] a, b, t);
      int ar, ai, br, bi, tr, ti;
      longint pr, pi;
      int r1, i1, r2, i2;
      ar = $signed(a[15:0]);  ai = $signed(a[31:16]);
      br = $signed(b[15:0]);  bi = $signed(b[31:16]);
      tr = $signed(t[15:0]);  ti = $signed(t[31:16]);
      pr = (longint'(br) * tr - longint'(bi) * ti) >>> 8;
      pi = (longint'(br) * ti + longint'(bi) * tr) >>> 8;
      r1 = ar + int'(pr);  i1 = ai + int'(pi);
      r2 = ar - int'(pr);  i2 = ai - int'(pi);
      return {16'(i2), 16'(r2), 16'(i1), 16'(r1)};
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_a = '0; m_b = '0; m_w = '0;
      m_out1 = '0; m_out2 = '0; m_rdy = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   task automatic check_model();
      check("out1", bus.out1, m_out1);
      check("out2", bus.out2, m_out2);
      check("rdy", {31'b0, bus.rdy}, {31'b0, m_rdy});
   endtask

   // One clock with the given enables/inputs, model update, then compare.
   task automatic step(input logic e1, input logic e2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] tw);
      logic [63:0] r;
      bus.enable_1 = e1;
      bus.enable_2 = e2;
      bus.data1    = d1;
      bus.data2    = d2;
      bus.w        = tw;
      @(posedge clk);
      ncyc++;
      if (rst_n) begin
         if (e2 && m_valid) begin
            r = bfly(m_a, m_b, m_w);
            m_out1 = r[31:0];
            m_out2 = r[63:32];
            m_rdy  = 1'b1;
            if (!e1) m_valid = 1'b0;
         end else begin
            m_rdy = 1'b0;
         end
         if (e1) begin
            m_a = d1; m_b = d2; m_w = tw;
            m_valid = 1'b1;
         end
      end
      #1;
      $display("cyc %0d rst_n=%b en=%b%b d1=%h d2=%h w=%h -> out1=%h out2=%h rdy=%b",
               ncyc, rst_n, e1, e2, d1, d2, tw, bus.out1, bus.out2, bus.rdy);
      check_model();
   endtask

   // Asynchronous reset pulse between edges; outputs must clear without a clock.
   task automatic async_reset_pulse();
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_model();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{32'h0000_3000, 32'h0000_2000, 32'h0000_0000, 32'h0000_3000, 32'h0000_3000};
      tbl[1] = '{32'h0000_0300, 32'h0180_0080, 32'h0200_0100, 32'h0280_0080, 32'hFD80_0580};
      tbl[2] = '{32'hFDE4_0339, 32'h0144_FDDD, 32'h0263_0025, 32'hF8F9_FFE4, 32'h02CF_068E};

      bus.enable_1 = 1'b0; bus.enable_2 = 1'b0;
      bus.data1 = '0; bus.data2 = '0; bus.w = '0;
      model_reset();

      // Reset held while inputs and enables toggle.
      rst_n = 1'b0;
      #1 check_model();
      for (int i = 0; i < 4; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
      #2 rst_n = 1'b1;
      step(1'b1, 1'b1, 32'h0100_0200, 32'h0100_0100, 32'h0000_0100);
      check("post_reset_rdy0", {31'b0, bus.rdy}, 32'd0);
      step(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
      check("post_reset_rdy1", {31'b0, bus.rdy}, 32'd1);
      step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0);

      // Directed butterflies from the table.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, tbl[i].d1, tbl[i].d2, tbl[i].tw);
         step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
         check($sformatf("tbl%0d_out1", i), bus.out1, tbl[i].e1);
         check($sformatf("tbl%0d_out2", i), bus.out2, tbl[i].e2);
         check($sformatf("tbl%0d_rdy", i), {31'b0, bus.rdy}, 32'd1);
      end

      // Enable gating: stage 1 loaded, stage 2 held off for three cycles.
      step(1'b1, 1'b0, tbl[1].d1, tbl[1].d2, tbl[1].tw);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, $urandom, $urandom, $urandom);
         check("gate_hold_rdy", {31'b0, bus.rdy}, 32'd0);
         check("gate_hold_out1", bus.out1, tbl[2].e1);
      end
      step(1'b0, 1'b1, $urandom, $urandom, $urandom);
      check("gate_release_out1", bus.out1, tbl[1].e1);
      check("gate_release_rdy", {31'b0, bus.rdy}, 32'd1);
      step(1'b0, 1'b1, $urandom, $urandom, $urandom);
      check("gate_single_pulse", {31'b0, bus.rdy}, 32'd0);

      // Streaming: four back-to-back samples, rdy high for exactly four cycles.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, $urandom, $urandom, $urandom);
      step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
      check("stream_last_rdy", {31'b0, bus.rdy}, 32'd1);
      step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
      check("stream_end_rdy", {31'b0, bus.rdy}, 32'd0);

      // Reset mid-operation discards the in-flight sample.
      step(1'b1, 1'b1, $urandom, $urandom, $urandom);
      step(1'b1, 1'b0, $urandom, $urandom, $urandom);
      async_reset_pulse();
      step(1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
      check("flush_rdy", {31'b0, bus.rdy}, 32'd0);
      check("flush_out1", bus.out1, 32'd0);

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              $urandom, $urandom, $urandom);
         if ($urandom_range(0, 49) == 0) async_reset_pulse();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
